vga_timing_receiver: RTL and testbench

Recovers raster timing from an incoming active-low HS/VS pair and regenerates pixel coordinates, an active-video flag and a lock status. It is the receiving end of the VGA sync interface driven by `vga_controller`. It is used on the bench and in bring-up loopback to confirm that the 640x480@60 timing driving the trading display is standard-compliant. It runs on the same 25 MHz pixel clock as the transmitter.

---
 rtl/vga_timing_receiver.sv | 167 ++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_receiver.sv
// Recovers raster position, active-video flag and lock status from an active-low HS/VS pair.
// Optional build macro VGA_RX_STATS_EN implements the saturating lock-loss counter on err_count.
module vga_timing_receiver #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_START     = 144,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_START     = 35,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic       locked,
  output logic       frame_pulse,
  output logic [7:0] err_count
);

  localparam logic [9:0]  HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  HStart     = 10'(H_START);
  localparam logic [9:0]  HEnd       = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]  VStart     = 10'(V_START);
  localparam logic [9:0]  VEnd       = 10'(V_START + V_ACTIVE);
  localparam logic [10:0] VTotal     = 11'(V_TOTAL);
  localparam logic [6:0]  HSync      = 7'(H_SYNC);
  localparam logic [7:0]  LockFrames = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  logic       hs_s1_q, hs_s2_q, hs_s3_q;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic       hs_fall, hs_rise, vs_fall;
  logic [9:0] h_pos_q, v_pos_q;
  logic [6:0] hs_low_q;
  logic       line_err_q;
  logic       err_evt;
  logic       frame_good;
  logic [10:0] line_count;
  logic [7:0] good_cnt_q, good_cnt_d;
  state_e     state_q, state_d;
  logic       in_win;

  assign hs_fall = ~hs_s2_q & hs_s3_q;
  assign hs_rise = hs_s2_q & ~hs_s3_q;
  assign vs_fall = ~vs_s2_q & vs_s3_q;

  // An HS edge coinciding with the VS edge still belongs to the closing frame.
  assign line_count = {1'b0, v_pos_q} + {10'd0, hs_fall};

  always_comb begin
    err_evt = 1'b0;
    if (hs_fall && (h_pos_q != HLast)) err_evt = 1'b1;
    if (!hs_fall && (h_pos_q == 10'd1022)) err_evt = 1'b1;
    if (hs_rise && (hs_low_q != HSync)) err_evt = 1'b1;
  end

  assign frame_good = (line_count == VTotal) && !line_err_q && !err_evt;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      StSearch: begin
        good_cnt_d = 8'd0;
        if (vs_fall) state_d = StAcquire;
      end
      StAcquire: begin
        if (vs_fall) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_d == LockFrames) state_d = StLocked;
          end else begin
            good_cnt_d = 8'd0;
          end
        end
      end
      StLocked: begin
        if (err_evt || (vs_fall && !frame_good)) begin
          state_d    = StSearch;
          good_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = StSearch;
        good_cnt_d = 8'd0;
      end
    endcase
  end

  // Uses the next state so pix_valid drops in the same cycle as locked.
  assign in_win = (state_d == StLocked) &&
                  (h_pos_q >= HStart) && (h_pos_q < HEnd) &&
                  (v_pos_q >= VStart) && (v_pos_q < VEnd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_s1_q     <= 1'b1;
      hs_s2_q     <= 1'b1;
      hs_s3_q     <= 1'b1;
      vs_s1_q     <= 1'b1;
      vs_s2_q     <= 1'b1;
      vs_s3_q     <= 1'b1;
      h_pos_q     <= 10'd1023;
      v_pos_q     <= 10'd1023;
      hs_low_q    <= 7'd0;
      line_err_q  <= 1'b0;
      state_q     <= StSearch;
      good_cnt_q  <= 8'd0;
      locked      <= 1'b0;
      frame_pulse <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
    end else begin
      hs_s1_q <= hs_in;
      hs_s2_q <= hs_s1_q;
      hs_s3_q <= hs_s2_q;
      vs_s1_q <= vs_in;
      vs_s2_q <= vs_s1_q;
      vs_s3_q <= vs_s2_q;

      if (hs_fall) h_pos_q <= 10'd0;
      else if (h_pos_q != 10'd1023) h_pos_q <= h_pos_q + 10'd1;

      if (hs_rise) hs_low_q <= 7'd0;
      else if (!hs_s2_q && (hs_low_q != 7'd127)) hs_low_q <= hs_low_q + 7'd1;

      if (vs_fall) v_pos_q <= 10'd0;
      else if (hs_fall && (v_pos_q != 10'd1023)) v_pos_q <= v_pos_q + 10'd1;

      line_err_q  <= vs_fall ? 1'b0 : (line_err_q | err_evt);
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      locked      <= (state_d == StLocked);
      frame_pulse <= vs_fall;
      pix_valid   <= in_win;
      pix_x       <= in_win ? (h_pos_q - HStart) : 10'd0;
      pix_y       <= in_win ? (v_pos_q - VStart) : 10'd0;
    end
  end

`ifdef VGA_RX_STATS_EN
  logic [7:0] err_cnt_q;
  logic       lock_loss;

  assign lock_loss = (state_q == StLocked) && (state_d == StSearch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (lock_loss && (err_cnt_q != 8'd255)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver: reduced raster, per-cycle scoreboard plus scenario checks.
module tb_vga_timing_receiver;

  localparam int HT  = 40;
  localparam int HSW = 6;
  localparam int HST = 10;
  localparam int HA  = 24;
  localparam int VT  = 20;
  localparam int VST = 4;
  localparam int VA  = 12;
  localparam int LF  = 2;
`ifdef VGA_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic [9:0] pix_x, pix_y;
  logic       pix_valid, locked, frame_pulse;
  logic [7:0] err_count;

  vga_timing_receiver #(
    .H_TOTAL(HT), .H_SYNC(HSW), .H_START(HST), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .locked(locked),
    .frame_pulse(frame_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit win;
    bit lk;
    bit vsf;
    int errc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (stimulus-side view of the lock machine).
  int m_state, m_good, m_lines, m_errcnt, prev_len;
  bit m_err;

  int max_x, max_y;
  bit seen_origin;

  function automatic int errc_exp(input int n);
    return STATS ? n : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_good = 0; m_lines = 1023; m_errcnt = 0; prev_len = 0; m_err = 1'b0;
  endtask

  task automatic model_lose();
    m_state = 0;
    m_good  = 0;
    if (m_errcnt < 255) m_errcnt++;
  endtask

  task automatic model_step(input bit hsf, input bit vsf, input bit evt);
    bit good;
    if (hsf && m_lines != 1023) m_lines++;
    good = (m_lines == VT) && !m_err && !evt;
    if (vsf) begin
      case (m_state)
        0: begin m_state = 1; m_good = 0; end
        1: begin
          if (good) begin
            m_good++;
            if (m_good == LF) m_state = 2;
          end else begin
            m_good = 0;
          end
        end
        default: if (!good) model_lose();
      endcase
    end else if (evt && m_state == 2) begin
      model_lose();
    end
    m_err = vsf ? 1'b0 : (m_err | evt);
    if (vsf) m_lines = 0;
  endtask

  task automatic drive_line(input int len, input int hsw, input int v);
    for (int i = 0; i < len; i++) begin
      bit   hsf, vsf, evt;
      int   h;
      exp_t e;
      hsf = (i == 0) && (hsw > 0);
      vsf = (i == 0) && (v == 0);
      evt = (hsf && prev_len != HT) || (i == hsw && hsw != HSW) || (i == 1023);
      h   = (i > 1023) ? 1023 : i;
      @(posedge clk);
      #1;
      hs_in = (i < hsw) ? 1'b0 : 1'b1;
      vs_in = (v < 2) ? 1'b0 : 1'b1;
      model_step(hsf, vsf, evt);
      e.win  = (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
      e.x    = e.win ? h - HST : 0;
      e.y    = e.win ? v - VST : 0;
      e.lk   = (m_state == 2);
      e.vsf  = vsf;
      e.errc = errc_exp(m_errcnt);
      sb_q.push_back(e);
    end
    prev_len = len;
  endtask

  task automatic drive_frame(input int nlines, input int sp_line, input int sp_len,
                             input int sp_hsw);
    for (int v = 0; v < nlines; v++) begin
      if (v == sp_line) drive_line(sp_len, sp_hsw, v);
      else drive_line(HT, HSW, v);
    end
  endtask

  // Scoreboard: entry k is due 4 clocks after it was driven; flags use entry k+1.
  exp_t   mon_e, mon_n;
  bit     mon_v;
  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      if (int'(pix_x) > max_x) max_x = int'(pix_x);
      if (int'(pix_y) > max_y) max_y = int'(pix_y);
      if (pix_x == 10'd0 && pix_y == 10'd0) seen_origin = 1'b1;
    end
    if (sb_q.size() >= 5) begin
      mon_e = sb_q.pop_front();
      mon_n = sb_q[0];
      mon_v = mon_e.win && mon_n.lk;
      checks += 6;
      if (pix_valid !== mon_v) begin
        errors++;
        $display("FAIL sb_pix_valid t=%0t got %b exp %b", $time, pix_valid, mon_v);
      end
      if (pix_x !== 10'(mon_v ? mon_e.x : 0)) begin
        errors++;
        $display("FAIL sb_pix_x t=%0t got %0d exp %0d", $time, pix_x, mon_v ? mon_e.x : 0);
      end
      if (pix_y !== 10'(mon_v ? mon_e.y : 0)) begin
        errors++;
        $display("FAIL sb_pix_y t=%0t got %0d exp %0d", $time, pix_y, mon_v ? mon_e.y : 0);
      end
      if (locked !== mon_n.lk) begin
        errors++;
        $display("FAIL sb_locked t=%0t got %b exp %b", $time, locked, mon_n.lk);
      end
      if (frame_pulse !== mon_n.vsf) begin
        errors++;
        $display("FAIL sb_frame_pulse t=%0t got %b exp %b", $time, frame_pulse, mon_n.vsf);
      end
      if (err_count !== 8'(mon_n.errc)) begin
        errors++;
        $display("FAIL sb_err_count t=%0t got %0d exp %0d", $time, err_count, mon_n.errc);
      end
    end
  end

  task automatic check_lock(input string name, input bit exp_lk, input int exp_err);
    @(negedge clk);
    checks += 2;
    if (locked !== exp_lk) begin
      errors++;
      $display("FAIL %s_locked got %b exp %b", name, locked, exp_lk);
    end
    if (err_count !== 8'(exp_err)) begin
      errors++;
      $display("FAIL %s_err_count got %0d exp %0d", name, err_count, exp_err);
    end
  endtask

  task automatic check_outputs_clear(input string name);
    checks += 6;
    if (locked !== 1'b0)      begin errors++; $display("FAIL %s locked got %b exp 0", name, locked); end
    if (pix_valid !== 1'b0)   begin errors++; $display("FAIL %s pix_valid got %b exp 0", name, pix_valid); end
    if (pix_x !== 10'd0)      begin errors++; $display("FAIL %s pix_x got %0d exp 0", name, pix_x); end
    if (pix_y !== 10'd0)      begin errors++; $display("FAIL %s pix_y got %0d exp 0", name, pix_y); end
    if (frame_pulse !== 1'b0) begin errors++; $display("FAIL %s frame_pulse got %b exp 0", name, frame_pulse); end
    if (err_count !== 8'd0)   begin errors++; $display("FAIL %s err_count got %0d exp 0", name, err_count); end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_clear("reset");
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_standard_lock();
    drive_frame(VT, -1, 0, 0);
    drive_frame(VT, -1, 0, 0);
    check_lock("before_3rd_vs", 1'b0, 0);
    drive_frame(VT, -1, 0, 0);
    check_lock("after_3rd_vs", 1'b1, 0);
    max_x = -1; max_y = -1; seen_origin = 1'b0;
    drive_frame(VT, -1, 0, 0);
    @(negedge clk);
    checks += 3;
    if (max_x != HA - 1) begin errors++; $display("FAIL last_pix_x got %0d exp %0d", max_x, HA - 1); end
    if (max_y != VA - 1) begin errors++; $display("FAIL last_pix_y got %0d exp %0d", max_y, VA - 1); end
    if (!seen_origin)    begin errors++; $display("FAIL first_pixel got none exp x=0 y=0 valid"); end
  endtask

  task automatic relock(input string name, input int exp_err);
    drive_frame(VT, -1, 0, 0);
    drive_frame(VT, -1, 0, 0);
    check_lock({name, "_relock_early"}, 1'b0, exp_err);
    drive_frame(VT, -1, 0, 0);
    check_lock({name, "_relock"}, 1'b1, exp_err);
  endtask

  task automatic test_short_line();
    drive_frame(VT, 5, HT - 1, HSW);
    check_lock("short_line", 1'b0, errc_exp(1));
    relock("short_line", errc_exp(1));
  endtask

  task automatic test_wide_hs();
    drive_frame(VT, 7, HT, HSW + 1);
    check_lock("wide_hs", 1'b0, errc_exp(2));
    relock("wide_hs", errc_exp(2));
  endtask

  task automatic test_hs_stuck_and_short_frame();
    drive_frame(VT, 3, 1100, HSW);
    check_lock("hs_stuck", 1'b0, errc_exp(3));
    drive_frame(VT, -1, 0, 0);
    drive_frame(VT - 1, -1, 0, 0);
    check_lock("short_frame", 1'b0, errc_exp(3));
    drive_frame(VT, -1, 0, 0);
    check_lock("after_short_frame_1", 1'b0, errc_exp(3));
    drive_frame(VT, -1, 0, 0);
    check_lock("after_short_frame_2", 1'b0, errc_exp(3));
    drive_frame(VT, -1, 0, 0);
    check_lock("short_frame_relock", 1'b1, errc_exp(3));
  endtask

  task automatic test_reset_midframe();
    for (int v = 0; v < 8; v++) drive_line(HT, HSW, v);
    check_lock("pre_reset", 1'b1, errc_exp(3));
    #2;
    sb_q.delete();
    reset = 1'b1;
    #1;
    check_outputs_clear("reset_midframe");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int v = 8; v < VT; v++) drive_line(HT, HSW, v);
    relock("reset_midframe", 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_standard_lock();
    test_short_line();
    test_wide_hs();
    test_hs_stuck_and_short_frame();
    test_reset_midframe();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
